// File: rtl/game_pkg.sv
// Shared types and defaults for the game sequencer: FSM state encoding,
// default move-period constants and the period calculation.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_e;

    localparam logic [23:0] DEFAULT_BASE_PERIOD = 24'd1_000_000;
    localparam logic [23:0] DEFAULT_STEP        = 24'd100_000;
    localparam logic [23:0] DEFAULT_MIN_PERIOD  = 24'd200_000;
    localparam logic [3:0]  DEFAULT_MAX_LEVEL   = 4'd8;

    // Compare before subtracting so a large level never underflows the period.
    function automatic logic [23:0] move_period(input logic [3:0]  lvl,
                                                input logic [23:0] base,
                                                input logic [23:0] step,
                                                input logic [23:0] min_p);
        logic [23:0] dec;
        dec = 24'(lvl) * step;
        if (dec >= base) begin
            return min_p;
        end
        if ((base - dec) < min_p) begin
            return min_p;
        end
        return base - dec;
    endfunction

endpackage

// File: rtl/move_timer.sv
// Move-rate timer: counts the level-dependent period while enabled and issues
// one registered tick per wrap, released on the next frame_done.
module move_timer
    import game_pkg::*;
#(
    parameter logic [23:0] BASE_PERIOD = DEFAULT_BASE_PERIOD,
    parameter logic [23:0] STEP        = DEFAULT_STEP,
    parameter logic [23:0] MIN_PERIOD  = DEFAULT_MIN_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [3:0] level,
    input  logic       frame_done,
    output logic       tick
);

    logic [23:0] count_q, count_d;
    logic        pending_q, pending_d;
    logic        tick_q, tick_d;
    logic [23:0] period;
    logic        wrap;
    logic        fire;

    always_comb begin
        period    = move_period(level, BASE_PERIOD, STEP, MIN_PERIOD);
        count_d   = count_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        wrap      = 1'b0;
        fire      = 1'b0;
        if (clear) begin
            count_d   = '0;
            pending_d = 1'b0;
        end else if (enable) begin
            // >= so a level-up that shrinks the period below the count wraps at once
            wrap      = (count_q + 24'd1) >= period;
            fire      = pending_q & frame_done;
            count_d   = wrap ? '0 : count_q + 24'd1;
            pending_d = (pending_q & ~fire) | wrap;
            tick_d    = fire;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Game control FSM: start/pause edge detection, apple counting and speed
// levels, driving the move timer and the game-block clear pulse.
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [23:0] BASE_PERIOD = DEFAULT_BASE_PERIOD,
    parameter logic [23:0] STEP        = DEFAULT_STEP,
    parameter logic [23:0] MIN_PERIOD  = DEFAULT_MIN_PERIOD,
    parameter logic [3:0]  MAX_LEVEL   = DEFAULT_MAX_LEVEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pb,
    input  logic       pause_pb,
    input  logic       goodColl,
    input  logic       badColl,
    input  logic       isGameComplete,
    input  logic       frame_done,
    output logic       move_tick,
    output logic       game_rst,
    output logic       run,
    output logic       game_over,
    output logic       win,
    output logic [3:0] level,
    output logic [2:0] state
);

    state_e      state_q, state_d;
    logic        start_prev_q, start_prev_d;
    logic        pause_prev_q, pause_prev_d;
    logic        arm_q, arm_d;
    logic        game_rst_q, game_rst_d;
    logic [1:0]  apples_q, apples_d;
    logic [3:0]  level_q, level_d;
    logic        start_edge;
    logic        pause_edge;

    // arm_q blocks edges for the first cycle after reset so a held button
    // is loaded into the edge registers instead of firing.
    always_comb begin
        start_edge   = arm_q & start_pb & ~start_prev_q;
        pause_edge   = arm_q & pause_pb & ~pause_prev_q;
        start_prev_d = start_pb;
        pause_prev_d = pause_pb;
        arm_d        = 1'b1;
        state_d      = state_q;
        apples_d     = apples_q;
        level_d      = level_q;

        case (state_q)
            S_IDLE:  if (start_edge) state_d = S_CLEAR;
            S_CLEAR: state_d = S_RUN;
            S_RUN: begin
                if (badColl) begin
                    state_d = S_OVER;
                end else if (isGameComplete) begin
                    state_d = S_WIN;
                end else if (pause_edge) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: if (pause_edge) state_d = S_RUN;
            S_OVER, S_WIN: if (start_edge) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_CLEAR) begin
            apples_d = '0;
            level_d  = '0;
        end else if ((state_q == S_RUN) && goodColl && !badColl) begin
            apples_d = apples_q + 2'd1;
            if ((apples_q == 2'd3) && (level_q < MAX_LEVEL)) begin
                level_d = level_q + 4'd1;
            end
        end

        game_rst_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            arm_q        <= 1'b0;
            game_rst_q   <= 1'b0;
            apples_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
            arm_q        <= arm_d;
            game_rst_q   <= game_rst_d;
            apples_q     <= apples_d;
            level_q      <= level_d;
        end
    end

    move_timer #(
        .BASE_PERIOD (BASE_PERIOD),
        .STEP        (STEP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_move_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (state_q == S_RUN),
        .clear      (state_q == S_CLEAR),
        .level      (level_q),
        .frame_done (frame_done),
        .tick       (move_tick)
    );

    assign game_rst  = game_rst_q;
    assign run       = (state_q == S_RUN);
    assign game_over = (state_q == S_OVER);
    assign win       = (state_q == S_WIN);
    assign level     = level_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (BASE_PERIOD=10, STEP=2, MIN_PERIOD=4):
// stimulus pushes expected move_tick cycles, a negedge monitor pops and compares.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_pb, pause_pb, goodColl, badColl, isGameComplete, frame_done;
    logic       move_tick, game_rst, run, game_over, win;
    logic [3:0] level;
    logic [2:0] state;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    game_sequencer #(
        .BASE_PERIOD (24'd10),
        .STEP        (24'd2),
        .MIN_PERIOD  (24'd4),
        .MAX_LEVEL   (4'd8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_pb       (start_pb),
        .pause_pb       (pause_pb),
        .goodColl       (goodColl),
        .badColl        (badColl),
        .isGameComplete (isGameComplete),
        .frame_done     (frame_done),
        .move_tick      (move_tick),
        .game_rst       (game_rst),
        .run            (run),
        .game_over      (game_over),
        .win            (win),
        .level          (level),
        .state          (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic at_cyc(input int n);
        if (cyc > n) begin
            n_checks++;
            $display("FAIL schedule: at cycle %0d, required cycle %0d", cyc, n);
        end
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: each move_tick must match the head of the expected-cycle queue.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            n_checks++;
            $display("FAIL tick_missing: no move_tick at cycle %0d, required one (now %0d)", exp_q[0], cyc);
            void'(exp_q.pop_front());
        end
        if (reset === 1'b0 && move_tick === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0)
                $display("FAIL tick_unexpected: move_tick at cycle %0d, expected none", cyc);
            else if (exp_q[0] != cyc)
                $display("FAIL tick_early: move_tick at cycle %0d, expected at %0d", cyc, exp_q[0]);
            else begin
                void'(exp_q.pop_front());
                n_pass++;
            end
        end
    end

    initial begin
        int t0, r, r2, r3, r4;
        // Ticks relative to the edge RUN begins: wrap at +P, registered tick at +P+1.
        int rel1[13] = '{11, 21, 42, 52, 60, 66, 72, 77, 81, 85, 89, 93, 97};
        int rel2[7]  = '{15, 22, 36, 43, 57, 64, 71};

        reset = 1'b1;
        start_pb = 1'b0; pause_pb = 1'b0; goodColl = 1'b0; badColl = 1'b0;
        isGameComplete = 1'b0; frame_done = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_move_tick", move_tick, 0);
        check("rst_game_rst", game_rst, 0);
        check("rst_level", level, 0);
        check("rst_run", run, 0);
        reset = 1'b0;
        @(negedge clk);

        // Start: CLEAR for one cycle, RUN from edge r.
        t0 = cyc + 2;
        at_cyc(t0);
        start_pb = 1'b1;
        r = t0 + 2;
        foreach (rel1[i]) exp_q.push_back(r + rel1[i]);
        at_cyc(t0 + 1);
        check("clear_state", state, 1);
        check("clear_game_rst", game_rst, 1);
        at_cyc(r);
        check("run_state", state, 2);
        check("run_game_rst", game_rst, 0);
        check("run_flag", run, 1);
        at_cyc(r + 3);
        start_pb = 1'b0;

        // Pause with timer frozen at 5; goodColl and start edge while paused are ignored.
        at_cyc(r + 24); pause_pb = 1'b1;
        at_cyc(r + 27); pause_pb = 1'b0;
        at_cyc(r + 28); check("pause_state", state, 3); goodColl = 1'b1;
        at_cyc(r + 30); start_pb = 1'b1;
        at_cyc(r + 32); start_pb = 1'b0; goodColl = 1'b0;
        at_cyc(r + 33); check("pause_start_ignored", state, 3); check("pause_good_ignored", level, 0);
        at_cyc(r + 35); pause_pb = 1'b1;
        at_cyc(r + 36); check("resume_state", state, 2);
        at_cyc(r + 38); pause_pb = 1'b0;

        // Eight apples -> level 2 (period 6), eight more -> level 4 (period floors at 4).
        at_cyc(r + 51); goodColl = 1'b1;
        at_cyc(r + 59); goodColl = 1'b0;
        at_cyc(r + 61); check("level_after_8", level, 2);
        at_cyc(r + 71); goodColl = 1'b1;
        at_cyc(r + 79); goodColl = 1'b0;
        at_cyc(r + 80); check("level_after_16", level, 4);

        // badColl with goodColl -> OVER, level held, ticks stop.
        at_cyc(r + 98); badColl = 1'b1; goodColl = 1'b1;
        at_cyc(r + 99); badColl = 1'b0; goodColl = 1'b0;
        check("over_state", state, 4);
        check("over_flag", game_over, 1);
        check("over_run", run, 0);
        check("over_level", level, 4);
        at_cyc(r + 110); frame_done = 1'b0;
        at_cyc(r + 115); start_pb = 1'b1;
        at_cyc(r + 116); check("restart_clear", state, 1); check("restart_game_rst", game_rst, 1);
        r2 = r + 117;
        at_cyc(r2);
        check("restart_run", state, 2);
        check("restart_level", level, 0);
        check("restart_over_flag", game_over, 0);
        foreach (rel2[i]) exp_q.push_back(r2 + rel2[i]);

        // frame_done every 7 cycles; wrap at r2+50 coincides with frame_done and must not tick.
        for (int k = 0; k <= 72; k++) begin
            at_cyc(r2 + k);
            frame_done = ((k % 7) == 0);
            if (k == 50) check("no_tick_on_wrap_frame", move_tick, 0);
        end

        // Reset mid-RUN with start_pb held high.
        at_cyc(r2 + 73);
        reset = 1'b1;
        #1;
        check("midrst_state", state, 0);
        check("midrst_run", run, 0);
        check("midrst_move_tick", move_tick, 0);
        check("midrst_game_rst", game_rst, 0);
        check("midrst_level", level, 0);
        check("midrst_over_win", {game_over, win}, 0);
        at_cyc(r2 + 76);
        reset = 1'b0;
        frame_done = 1'b1;
        for (int k = 77; k <= 81; k++) begin
            at_cyc(r2 + k);
            check("held_start_no_restart", state, 0);
        end
        at_cyc(r2 + 82); start_pb = 1'b0;
        at_cyc(r2 + 84); start_pb = 1'b1;
        at_cyc(r2 + 85); check("rearm_clear", state, 1);
        r3 = r2 + 86;
        at_cyc(r3); check("rearm_run", state, 2);

        // badColl has priority over isGameComplete.
        at_cyc(r3 + 3); badColl = 1'b1; isGameComplete = 1'b1;
        at_cyc(r3 + 4); badColl = 1'b0; isGameComplete = 1'b0;
        check("prio_over_state", state, 4);
        check("prio_win_flag", win, 0);
        at_cyc(r3 + 5); start_pb = 1'b0;
        at_cyc(r3 + 7); start_pb = 1'b1;
        r4 = r3 + 9;
        at_cyc(r4); check("win_run", state, 2);
        at_cyc(r4 + 2); isGameComplete = 1'b1;
        at_cyc(r4 + 3); isGameComplete = 1'b0;
        check("win_state", state, 5);
        check("win_flag", win, 1);
        check("win_run_flag", run, 0);

        at_cyc(r4 + 20);
        check("tick_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 24'd1_000_000, clk cycles per move at level 0.
REQ-002 SHALL have parameter STEP, default 24'd100_000, period decrease per level.
REQ-003 SHALL have parameter MIN_PERIOD, default 24'd200_000, floor on move period.
REQ-004 SHALL have parameter MAX_LEVEL, default 4'd8, level saturation value.
REQ-005 SHALL have ports:
- clk, input, 1: system clock; single clock domain, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start_pb, input, 1: start request; level signal, already synchronized.
- pause_pb, input, 1: pause toggle; level signal, already synchronized.
- goodColl, input, 1: apple eaten; one-cycle pulse.
- badColl, input, 1: fatal collision; level or pulse.
- isGameComplete, input, 1: maximum length reached.
- frame_done, input, 1: display frame finished; one-cycle pulse.
- move_tick, output, 1: one-cycle pulse advancing the snake one cell.
- game_rst, output, 1: one-cycle synchronous clear for game blocks.
- run, output, 1: high in RUN.
- game_over, output, 1: high in OVER.
- win, output, 1: high in WIN.
- level, output, 4: current speed level.
- state, output, 3: encoded FSM state.

Function
REQ-006 SHALL detect rising edges of start_pb and pause_pb internally (current & ~previous registered value).
REQ-007 SHALL implement states IDLE=0, CLEAR=1, RUN=2, PAUSE=3, OVER=4, WIN=5.
REQ-008 IDLE: start edge -> CLEAR; all other inputs ignored.
REQ-009 CLEAR SHALL last exactly one cycle with game_rst=1, then go to RUN; SHALL zero level, apple count, timer and pending flag.
REQ-010 RUN transition priority: badColl -> OVER; else isGameComplete -> WIN; else pause edge -> PAUSE; else stay.
REQ-011 PAUSE: pause edge -> RUN; start edge ignored; timer and pending flag hold.
REQ-012 OVER and WIN: start edge -> CLEAR; everything else ignored.
REQ-013 Move period SHALL be max(BASE_PERIOD - level*STEP, MIN_PERIOD), computed in 24 bits with no underflow (compare before subtracting).
REQ-014 Timer SHALL count only in RUN, from 0 to period-1; at period-1 it wraps to 0 and sets pending.
REQ-015 move_tick SHALL pulse for one cycle on the first frame_done while pending=1 in RUN; pending clears in that cycle.
REQ-016 A new wrap while pending=1 SHALL NOT queue a second tick.
REQ-017 If frame_done and a timer wrap occur in the same cycle with pending=0, move_tick SHALL NOT fire in that cycle; pending SHALL be set.
REQ-018 goodColl in RUN with badColl=0 SHALL increment a 2-bit apple count.
REQ-019 When the apple count wraps 3->0, level SHALL increment, saturating at MAX_LEVEL.
REQ-020 goodColl outside RUN, or together with badColl, SHALL be ignored.
REQ-021 run, game_over and win SHALL be Moore outputs decoded from state; move_tick and game_rst SHALL be registered outputs.
REQ-022 A level change SHALL take effect on the next timer comparison; the current count SHALL NOT reset.

Reset
REQ-023 On reset: state=IDLE, move_tick=0, game_rst=0, level=0, apple count=0, timer=0, pending=0, edge registers=0.
REQ-024 Reset asserted mid-game SHALL return the block to IDLE immediately; deassertion SHALL NOT itself produce a start edge if start_pb is held high (edge registers are only loaded from start_pb after reset releases).

Structure
REQ-025 Package game_pkg SHALL hold the state enum (3-bit), MAX_LEVEL and the default period constants.
REQ-026 SHALL instantiate one sub-module, move_timer, containing the period computation, counter and pending flag, with inputs enable, clear, level and frame_done and output tick.

Verification
Benches use BASE_PERIOD=10, STEP=2, MIN_PERIOD=4 with frame_done tied high.
REQ-027 Reset, then start_pb rising -> game_rst high exactly one cycle, state=RUN next cycle, first move_tick 10 cycles later, then every 10 cycles.
REQ-028 Eight goodColl pulses in RUN -> level=2, move_tick period 6; after 16 pulses level=4, period floors at 4 (not 2).
REQ-029 Pause edge mid-count (timer=5) -> no move_tick while paused; second pause edge -> next move_tick 5 cycles after resume.
REQ-030 badColl and goodColl asserted in the same cycle in RUN -> state=OVER, level unchanged, no further move_tick; start edge -> CLEAR, then RUN with level=0.
REQ-031 frame_done pulsing every 7 cycles -> each move_tick coincides with frame_done and never two ticks per wrap.
REQ-032 Reset asserted during RUN with start_pb held high -> IDLE, all outputs 0, no restart until start_pb falls and rises again.
